vga_sync_gen: RTL and testbench

- Downstream consumer of the horizontal/vertical pixel counters in the VGA signal generator.
- Samples h_count/v_count on each pixel tick and tracks the horizontal and vertical timing regions with two small FSMs.
- Drives registered hsync, vsync, video_on, pixel coordinates and line/frame start strobes to the colour/output stage.

---
 rtl/vga_sync_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_sync_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA sync generator: tracks horizontal/vertical timing regions from the upstream
// pixel counters and drives registered sync, blanking, coordinates and strobes.
// Optional VGA_SYNC_CHECK_EN adds desync detection and FSM realignment.
module vga_sync_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CNT_WIDTH = 10,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic [CNT_WIDTH-1:0] h_count,
    input  logic [CNT_WIDTH-1:0] v_count,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [CNT_WIDTH-1:0] pix_x,
    output logic [CNT_WIDTH-1:0] pix_y,
    output logic                 line_start,
    output logic                 frame_start
`ifdef VGA_SYNC_CHECK_EN
    ,
    output logic                 desync,
    output logic [7:0]           err_count
`endif
);

    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] FP     = 2'd1;
    localparam logic [1:0] SYNC   = 2'd2;
    localparam logic [1:0] BP     = 2'd3;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each region
    localparam logic [CNT_WIDTH-1:0] H_A_END = CNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] H_F_END = CNT_WIDTH'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_WIDTH-1:0] H_S_END = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_A_END = CNT_WIDTH'(V_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] V_F_END = CNT_WIDTH'(V_ACTIVE + V_FP - 1);
    localparam logic [CNT_WIDTH-1:0] V_S_END = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);

    function automatic logic [1:0] advance(
        input logic [1:0]           st,
        input logic [CNT_WIDTH-1:0] c,
        input logic [CNT_WIDTH-1:0] a_end,
        input logic [CNT_WIDTH-1:0] f_end,
        input logic [CNT_WIDTH-1:0] s_end,
        input logic [CNT_WIDTH-1:0] last
    );
        logic [1:0] nx;
        nx = st;
        case (st)
            ACTIVE:  if (c == a_end) nx = FP;
            FP:      if (c == f_end) nx = SYNC;
            SYNC:    if (c == s_end) nx = BP;
            default: if (c == last)  nx = ACTIVE;
        endcase
        return nx;
    endfunction

`ifdef VGA_SYNC_CHECK_EN
    function automatic logic [1:0] decode(
        input logic [CNT_WIDTH-1:0] c,
        input logic [CNT_WIDTH-1:0] a_end,
        input logic [CNT_WIDTH-1:0] f_end,
        input logic [CNT_WIDTH-1:0] s_end
    );
        if (c <= a_end)      return ACTIVE;
        else if (c <= f_end) return FP;
        else if (c <= s_end) return SYNC;
        else                 return BP;
    endfunction
`endif

    logic [1:0] h_state, v_state;
    logic [1:0] h_cur, v_cur, h_reg, v_reg, h_nxt, v_nxt;
    logic       h_oor, v_oor, line_end, vid, ls, fs;
`ifdef VGA_SYNC_CHECK_EN
    logic [1:0] h_dec, v_dec;
    logic       mismatch;
`endif

    always_comb begin
        h_oor    = h_count > H_LAST;
        v_oor    = v_count > V_LAST;
        line_end = h_count == H_LAST;
`ifdef VGA_SYNC_CHECK_EN
        h_dec    = decode(h_count, H_A_END, H_F_END, H_S_END);
        v_dec    = decode(v_count, V_A_END, V_F_END, V_S_END);
        mismatch = (h_dec != h_state) || (v_dec != v_state);
        h_cur    = mismatch ? h_dec : h_state;
        v_cur    = mismatch ? v_dec : v_state;
`else
        h_cur    = h_state;
        v_cur    = v_state;
`endif
        // Counts beyond the frame are blanked as back porch regardless of FSM
        h_reg    = h_oor ? BP : h_cur;
        v_reg    = v_oor ? BP : v_cur;
        h_nxt    = advance(h_cur, h_count, H_A_END, H_F_END, H_S_END, H_LAST);
        v_nxt    = line_end ? advance(v_cur, v_count, V_A_END, V_F_END, V_S_END, V_LAST)
                            : v_cur;
        vid      = (h_reg == ACTIVE) && (v_reg == ACTIVE);
        ls       = (h_count == '0) && !v_oor;
        fs       = ls && (v_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_state     <= ACTIVE;
            v_state     <= ACTIVE;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_SYNC_CHECK_EN
            desync      <= 1'b0;
            err_count   <= 8'd0;
`endif
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_SYNC_CHECK_EN
            desync      <= 1'b0;
`endif
            if (pix_en) begin
                h_state     <= h_nxt;
                v_state     <= v_nxt;
                hsync       <= (h_reg == SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (v_reg == SYNC) ? SYNC_POL : ~SYNC_POL;
                video_on    <= vid;
                pix_x       <= vid ? h_count : '0;
                pix_y       <= vid ? v_count : '0;
                line_start  <= ls;
                frame_start <= fs;
`ifdef VGA_SYNC_CHECK_EN
                if (mismatch) begin
                    desync <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: expected outputs are derived from the raster
// region boundaries when each sample is driven and compared one clk later.
module tb_vga_sync_gen;
    localparam int W      = 10;
    localparam int HA     = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA     = 480, VF = 10, VS = 2, VB = 33;
    localparam int H_TOT  = HA + HF + HS + HB;
    localparam int V_TOT  = VA + VF + VS + VB;
    localparam bit POL    = 1'b0;

    logic         clk = 1'b0;
    logic         rst, pix_en;
    logic [W-1:0] h_count, v_count;
    logic         hsync, vsync, video_on, line_start, frame_start;
    logic [W-1:0] pix_x, pix_y;
    logic         ds_w;
    logic [7:0]   ec_w;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CNT_WIDTH(W), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_SYNC_CHECK_EN
        , .desync(ds_w), .err_count(ec_w)
`endif
    );

`ifndef VGA_SYNC_CHECK_EN
    assign ds_w = 1'b0;
    assign ec_w = 8'd0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    string phase = "reset";
    int ls_cnt, fs_cnt;

    // Expected level outputs (hold across idle cycles)
    logic         e_hs, e_vs, e_vid;
    logic [W-1:0] e_px, e_py;
    logic [7:0]   e_ec;
    logic [1:0]   ehs, evs;

    int hl[16] = '{0, 1, 100, 638, 639, 640, 641, 655, 656, 657, 700, 750, 751, 752, 798, 799};

    logic [63:0] dut_vec;
    assign dut_vec = {30'd0, ds_w, ec_w, hsync, vsync, video_on, pix_x, pix_y, line_start, frame_start};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rg(input int c, input int a, input int f, input int s);
        if (c < a)              return 2'd0;
        else if (c < a + f)     return 2'd1;
        else if (c < a + f + s) return 2'd2;
        else                    return 2'd3;
    endfunction

    task automatic finish_step(input logic [63:0] exp);
        logic [63:0] e;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (line_start)  ls_cnt++;
        if (frame_start) fs_cnt++;
        e = sb.pop_front();
        chk(phase, dut_vec, e);
    endtask

    task automatic step(input bit en, input int h, input int v);
        logic [1:0] hr, vr;
        logic ls, fs, ds;
        rst = 1'b0;
        pix_en = en;
        h_count = W'(h);
        v_count = W'(v);
        ls = 1'b0;
        fs = 1'b0;
        ds = 1'b0;
        if (en) begin
            hr    = rg(h, HA, HF, HS);
            vr    = rg(v, VA, VF, VS);
            e_hs  = (hr == 2'd2) ? POL : ~POL;
            e_vs  = (vr == 2'd2) ? POL : ~POL;
            e_vid = (hr == 2'd0) && (vr == 2'd0);
            e_px  = e_vid ? W'(h) : '0;
            e_py  = e_vid ? W'(v) : '0;
            ls    = (h == 0) && (v < V_TOT);
            fs    = ls && (v == 0);
`ifdef VGA_SYNC_CHECK_EN
            if ((hr != ehs) || (vr != evs)) begin
                ds = 1'b1;
                if (e_ec != 8'hFF) e_ec = e_ec + 8'd1;
            end
            ehs = rg((h + 1) % H_TOT, HA, HF, HS);
            evs = (h == H_TOT - 1) ? rg((v + 1) % V_TOT, VA, VF, VS) : vr;
`endif
        end
        finish_step({30'd0, ds, e_ec, e_hs, e_vs, e_vid, e_px, e_py, ls, fs});
    endtask

    task automatic do_reset(input int h, input int v);
        rst = 1'b1;
        pix_en = 1'b1;
        h_count = W'(h);
        v_count = W'(v);
        e_hs = ~POL; e_vs = ~POL; e_vid = 1'b0;
        e_px = '0; e_py = '0; e_ec = 8'd0;
        ehs = 2'd0; evs = 2'd0;
        finish_step({30'd0, 1'b0, 8'd0, ~POL, ~POL, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0});
    endtask

    task automatic run_line(input int v, input int gap, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step(1'b1, hl[i], v);
            for (int g = 1; g < gap; g++)
                step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; h_count = '0; v_count = '0;
        ls_cnt = 0; fs_cnt = 0;
        do_reset(0, 0);

        phase = "frame";
        ls_cnt = 0; fs_cnt = 0;
        for (int v = 0; v < V_TOT; v++) run_line(v, 1, 0, 15);
        chk("line_start_count", 64'(ls_cnt), 64'd525);
        chk("frame_start_count", 64'(fs_cnt), 64'd1);

        phase = "en_every4";
        ls_cnt = 0;
        for (int v = 0; v < 4; v++) run_line(v, 4, 0, 15);
        chk("en4_line_start_count", 64'(ls_cnt), 64'd4);

        phase = "pre_reset";
        for (int v = 4; v < 300; v++) run_line(v, 1, 0, 15);
        run_line(300, 1, 0, 10);
        phase = "mid_reset";
        do_reset(701, 300);

        phase = "resume";
        for (int v = 0; v < 3; v++) run_line(v, 1, 0, 15);

`ifdef VGA_SYNC_CHECK_EN
        phase = "desync_jump";
        run_line(3, 1, 0, 2);
        step(1'b1, 700, 3);
        chk("err_after_jump", 64'(ec_w), 64'd1);
        phase = "desync_track";
        run_line(3, 1, 11, 15);
        phase = "desync_sat";
        for (int k = 0; k < 150; k++) begin
            step(1'b1, 100, 4);
            step(1'b1, 700, 4);
        end
        chk("err_saturated", 64'(ec_w), 64'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
